// File: rtl/fano_pkg.sv
// Shared definitions for the Fano convolutional encoder/decoder pair:
// code-rate encoding, puncturing tables, default generators and QPSK tables.
package fano_pkg;

  // Selectable punctured code rates; the encoding matches the i_code_rate port.
  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2,
    RATE_7_8 = 2'd3
  } code_rate_e;

  // Number of encoder input bits in one puncturing period.
  localparam logic [2:0] PERIOD_1_2 = 3'd1;
  localparam logic [2:0] PERIOD_2_3 = 3'd2;
  localparam logic [2:0] PERIOD_3_4 = 3'd3;
  localparam logic [2:0] PERIOD_7_8 = 3'd7;

  // Default generator polynomials of the rate-1/2 mother code (K = 24).
  localparam logic [23:0] DEFAULT_G0 = 24'h8E4D2F;
  localparam logic [23:0] DEFAULT_G1 = 24'hF1B3A5;

  // Keep mask per rate and phase, each entry {keep_c1, keep_c0}.
  // Rows list phases 7 down to 0; unused phases are 00 and never reached.
  //   1/2: p0 c0c1
  //   2/3: p0 c0c1, p1 c1
  //   3/4: p0 c0c1, p1 c1, p2 c0
  //   7/8: p0 c0c1, p1..p3 c1, p4 c0, p5 c1, p6 c0
  localparam logic [3:0][7:0][1:0] PUNCT_MASK = {
    16'b00_01_10_01_10_10_10_11,
    16'b00_00_00_00_00_01_10_11,
    16'b00_00_00_00_00_00_10_11,
    16'b00_00_00_00_00_00_00_11
  };

  // Gray dibit {b0,b1} to phase increment: 00->0, 01->1, 11->2, 10->3.
  localparam logic [3:0][1:0] GRAY_INDEX = {2'd2, 2'd3, 2'd1, 2'd0};

  // Absolute phase to {I negative, Q negative}:
  // 0:(+,+) 1:(-,+) 2:(-,-) 3:(+,-).
  localparam logic [3:0][1:0] PHASE_NEG = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [2:0] punct_period(input code_rate_e rate);
    logic [2:0] period;
    unique case (rate)
      RATE_1_2: period = PERIOD_1_2;
      RATE_2_3: period = PERIOD_2_3;
      RATE_3_4: period = PERIOD_3_4;
      RATE_7_8: period = PERIOD_7_8;
      default:  period = PERIOD_1_2;
    endcase
    return period;
  endfunction

  function automatic logic [1:0] punct_keep(input code_rate_e rate,
                                            input logic [2:0] phase);
    return PUNCT_MASK[rate][phase];
  endfunction

endpackage

// File: rtl/qpsk_mapper.sv
// QPSK symbol mapper: optional differential phase accumulation followed by
// sign mapping onto +/-AMP, with registered I/Q samples and a valid pulse.
module qpsk_mapper
  import fano_pkg::*;
#(
  parameter int IQ_WIDTH = 10,
  parameter int AMP      = 362
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       diff_en,
  input  logic                       sym_pop,
  input  logic                       b0,
  input  logic                       b1,
  output logic                       sym_vld,
  output logic signed [IQ_WIDTH-1:0] sym_i,
  output logic signed [IQ_WIDTH-1:0] sym_q
);

  localparam logic signed [IQ_WIDTH-1:0] POS_AMP = IQ_WIDTH'(AMP);
  localparam logic signed [IQ_WIDTH-1:0] NEG_AMP = -POS_AMP;

  logic [1:0] phase;
  logic [1:0] phase_new;
  logic [1:0] neg_iq;

  // Work out the new differential phase and which rails go negative.
  always_comb begin
    phase_new = phase + GRAY_INDEX[{b0, b1}];
    neg_iq    = {b0, b1};
    if (diff_en) begin
      neg_iq = PHASE_NEG[phase_new];
    end
  end

  // Register the sample pair and the phase; samples hold between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= 2'd0;
      sym_vld <= 1'b0;
      sym_i   <= '0;
      sym_q   <= '0;
    end else begin
      sym_vld <= sym_pop;
      if (sym_pop) begin
        sym_i <= neg_iq[1] ? NEG_AMP : POS_AMP;
        sym_q <= neg_iq[0] ? NEG_AMP : POS_AMP;
        if (diff_en) begin
          phase <= phase_new;
        end
      end
    end
  end

endmodule

// File: rtl/fano_conv_encoder.sv
// Per-channel transmit encoder: byte buffer, K=24 rate-1/2 convolutional
// encoder, puncturing to the selected rate, an 8-bit coded-bit accumulator
// and a QPSK mapper producing samples in the decoder's input format.
module fano_conv_encoder
  import fano_pkg::*;
#(
  parameter int           K        = 24,
  parameter logic [K-1:0] G0       = K'(DEFAULT_G0),
  parameter logic [K-1:0] G1       = K'(DEFAULT_G1),
  parameter int           IQ_WIDTH = 10,
  parameter int           AMP      = 362
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 i_code_rate,
  input  logic                       i_diff_en,
  input  logic                       i_vld,
  input  logic [7:0]                 i_data,
  output logic                       o_rdy,
  input  logic                       i_sym_en,
  output logic                       o_vld,
  output logic signed [IQ_WIDTH-1:0] o_data_I,
  output logic signed [IQ_WIDTH-1:0] o_data_Q,
  output logic                       o_underflow
);

  code_rate_e rate;

  // Byte buffer
  logic [7:0] byte_sr;
  logic [3:0] bit_cnt;
  logic       byte_take;

  // Encoder state; only the K-1 previous bits are stored, the bit being
  // encoded completes the K-bit window.
  logic [K-2:0] sr;
  logic [K-1:0] sr_new;
  logic [2:0]   punct_phase;
  logic [2:0]   phase_last;
  logic         enc_en;
  logic         c0;
  logic         c1;
  logic [1:0]   keep;
  logic [1:0]   enc_bits;
  logic [3:0]   enc_cnt;

  // Coded-bit accumulator, oldest bit at acc[7], unused low bits kept at 0.
  logic [7:0] acc;
  logic [3:0] acc_cnt;
  logic [7:0] acc_base;
  logic [3:0] cnt_base;
  logic [7:0] acc_next;
  logic [3:0] acc_cnt_next;
  logic       sym_pop;
  logic       sym_starve;
  logic       underflow;

  assign rate       = code_rate_e'(i_code_rate);
  assign o_rdy      = (bit_cnt == 4'd0);
  assign byte_take  = i_vld && o_rdy;
  assign enc_en     = (bit_cnt != 4'd0) && (acc_cnt <= 4'd6);
  assign sym_pop    = i_sym_en && (acc_cnt >= 4'd2);
  assign sym_starve = i_sym_en && (acc_cnt < 4'd2);
  assign o_underflow = underflow;

  // Encode the current MSB against both generators and look up the puncture mask.
  always_comb begin
    sr_new     = {sr, byte_sr[7]};
    c0         = ^(sr_new & G0);
    c1         = ^(sr_new & G1);
    keep       = punct_keep(rate, punct_phase);
    phase_last = punct_period(rate) - 3'd1;
  end

  // Turn the kept coded bits into an MSB-aligned pair plus a count, c0 first.
  always_comb begin
    enc_bits = 2'b00;
    enc_cnt  = 4'd0;
    if (enc_en) begin
      unique case (keep)
        2'b11: begin
          enc_bits = {c0, c1};
          enc_cnt  = 4'd2;
        end
        2'b10: begin
          enc_bits = {c1, 1'b0};
          enc_cnt  = 4'd1;
        end
        2'b01: begin
          enc_bits = {c0, 1'b0};
          enc_cnt  = 4'd1;
        end
        default: begin
          enc_bits = 2'b00;
          enc_cnt  = 4'd0;
        end
      endcase
    end
  end

  // Pop first, then append new bits right behind whatever remains so that a
  // same-cycle pop and push keep FIFO order.
  always_comb begin
    acc_base = acc;
    cnt_base = acc_cnt;
    if (sym_pop) begin
      acc_base = {acc[5:0], 2'b00};
      cnt_base = acc_cnt - 4'd2;
    end
    acc_next     = acc_base | ({enc_bits, 6'b000000} >> cnt_base);
    acc_cnt_next = cnt_base + enc_cnt;
  end

  // Byte buffer: load on acceptance, shift out one bit per encode step.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_sr <= 8'h00;
      bit_cnt <= 4'd0;
    end else if (byte_take) begin
      byte_sr <= i_data;
      bit_cnt <= 4'd8;
    end else if (enc_en) begin
      byte_sr <= {byte_sr[6:0], 1'b0};
      bit_cnt <= bit_cnt - 4'd1;
    end
  end

  // Encoder shift register and puncture phase advance once per encoded bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr          <= '0;
      punct_phase <= 3'd0;
    end else if (enc_en) begin
      sr          <= sr_new[K-2:0];
      punct_phase <= (punct_phase == phase_last) ? 3'd0 : punct_phase + 3'd1;
    end
  end

  // Accumulator contents and fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= 8'h00;
      acc_cnt <= 4'd0;
    end else begin
      acc     <= acc_next;
      acc_cnt <= acc_cnt_next;
    end
  end

  // Sticky flag for a symbol request that found fewer than two coded bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (sym_starve) begin
      underflow <= 1'b1;
    end
  end

  qpsk_mapper #(
    .IQ_WIDTH (IQ_WIDTH),
    .AMP      (AMP)
  ) u_mapper (
    .clk     (clk),
    .reset   (reset),
    .diff_en (i_diff_en),
    .sym_pop (sym_pop),
    .b0      (acc[7]),
    .b1      (acc[6]),
    .sym_vld (o_vld),
    .sym_i   (o_data_I),
    .sym_q   (o_data_Q)
  );

endmodule

// File: doc/fano_conv_encoder.md
Name: fano_conv_encoder

Overview:
- Transmit-side counterpart of the per-channel Fano sequential decoder.
- Takes a byte stream and convolutionally encodes it: rate-1/2 mother code, long constraint length, punctured to the selected code rate.
- Optionally differentially encodes, then maps to QPSK I/Q samples in the exact format the decoder consumes.
- Used for loopback self-test and for the modulator path; one instance per channel.

Parameters:
K, 24, constraint length (shift-register width)
G0, 24'h8E4D2F, generator polynomial for coded bit c0 (bit 0 must be 1)
G1, 24'hF1B3A5, generator polynomial for coded bit c1 (bit 0 must be 1)
IQ_WIDTH, 10, signed output sample width
AMP, 362, QPSK amplitude magnitude, must be < 2^(IQ_WIDTH-1)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
i_code_rate  in  2  0=1/2, 1=2/3, 2=3/4, 3=7/8; quasi-static, changes only under reset
i_diff_en  in  1  differential QPSK enable; quasi-static
i_vld  in  1  input byte valid
i_data  in  8  input byte, transmitted MSB first
o_rdy  out  1  byte buffer empty; byte accepted when i_vld && o_rdy
i_sym_en  in  1  symbol-rate strobe requesting one QPSK symbol
o_vld  out  1  output symbol valid, one-cycle pulse
o_data_I  out  IQ_WIDTH  signed I sample
o_data_Q  out  IQ_WIDTH  signed Q sample
o_underflow  out  1  sticky: i_sym_en arrived with fewer than 2 coded bits buffered

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset state:
  - All outputs 0 except o_rdy=1.
  - Shift register sr=0, puncture phase p=0, accumulator count=0, differential phase=0.
  - Reset mid-operation discards the buffered byte, coded bits and the symbol in flight; the following cycle starts clean.
- Byte buffer:
  - Accepting a byte loads an 8-bit shift register and sets bit_cnt=8.
  - o_rdy = (bit_cnt==0).
  - A byte is never accepted in the same cycle its last bit is encoded; o_rdy rises the cycle after.
- Encode step, one input bit per clock, enabled when bit_cnt>0 and count<=6:
  - sr <= {sr[K-2:0], bit}.
  - c0 = ^(sr_new & G0), c1 = ^(sr_new & G1).
  - bit_cnt decrements.
- Puncture: emitted bits per phase p (c0 before c1). The period wraps p to 0.
  - Rate 1/2, period 1: p0: c0 c1.
  - Rate 2/3, period 2: p0: c0 c1; p1: c1 (3 bits per period).
  - Rate 3/4, period 3: p0: c0 c1; p1: c1; p2: c0 (4 bits per period).
  - Rate 7/8, period 7: p0: c0 c1; p1..p3: c1; p4: c0; p5: c1; p6: c0 (8 bits per period).
- Coded-bit accumulator:
  - 8-bit FIFO-ordered register with count 0..8.
  - The room check uses the pre-cycle count.
  - Same-cycle add k bits and consume 2 bits gives count_next = count + k - 2, with bit order preserved.
- Symbol emission:
  - On i_sym_en with count>=2: pop dibit {b0 = oldest, b1}; o_vld=1 next cycle with registered I/Q.
  - On i_sym_en with count<2: nothing is popped, o_vld stays 0, o_underflow <= 1 (cleared only by reset).
- Mapping with i_diff_en=0:
  - I = b0 ? -AMP : +AMP; Q = b1 ? -AMP : +AMP.
- Mapping with i_diff_en=1:
  - q = gray index: 00→0, 01→1, 11→2, 10→3.
  - phase <= (phase + q) mod 4.
  - Output the new phase: 0:(+A,+A), 1:(-A,+A), 2:(-A,-A), 3:(+A,-A).
- o_data_I/Q hold their value between pulses; they are meaningful only when o_vld=1.
- Latency: byte accepted at edge t → first coded bits in the accumulator after edge t+1 → earliest o_vld at edge t+3 (i_sym_en sampled at edge t+2).

Decomposition:
- fano_pkg (shared with the decoder): code-rate enum, puncture period constants, puncture keep-mask table indexed by rate and phase, default G0/G1, QPSK gray table.
- Sub-module qpsk_mapper: differential phase register plus gray/sign mapping, registered output and o_vld.

Test Plan:
- Underflow: after reset, i_sym_en=1 for one cycle with no data → o_vld=0, o_underflow=1 next cycle and stays 1 until reset.
- First symbol: rate 1/2, diff off, byte 0x80, then one i_sym_en once count>=2 → o_vld=1, o_data_I = o_data_Q = -362 (10'h296).
- Rate 2/3 bit count: 2 bytes (16 bits → 24 coded bits) → exactly 12 symbols; 13th strobe sets o_underflow.
- Rate 7/8 bit count: 7 bytes (56 → 64 coded bits) → exactly 32 symbols; 33rd strobe underflows.
- Differential mode: byte 0x00 after reset, diff on → all dibits 00 (sr stays 0), 8 symbols of (+362,+362). Then byte 0x80 → first dibit 11, phase 2 → (-362,-362).
- Reset mid-stream: assert reset with bit_cnt=5, count=5 → next cycle o_rdy=1, o_vld=0, I=Q=0, o_underflow=0. A following 0x80 reproduces the first-symbol result exactly.
